// File: rtl/z80_pkg.sv
// z80_pkg: shared types and helpers for the Z80 bus-cycle sequencer.
//   bus_cyc_t  - bus cycle kinds requested by the control logic
//   t_state_t  - T-state of the machine cycle in progress
//   bus_out_t  - bundle of every registered bus/datapath control output
//   RFSH_MASK  - bit 7 of the refresh address is always held at 0
//   decode_bus - output bundle for a given T-state and cycle type
package z80_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        MEM_RD = 3'd1,
        MEM_WR = 3'd2,
        IO_RD  = 3'd3,
        IO_WR  = 3'd4
    } bus_cyc_t;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        T4
    } t_state_t;

    localparam logic [7:0] RFSH_MASK = 8'h7F;

    typedef struct packed {
        logic m1_l;
        logic mreq_l;
        logic iorq_l;
        logic rd_l;
        logic wr_l;
        logic rfsh_l;
        logic latch;
        logic done;
        logic drive;
        logic addr_sel;
    } bus_out_t;

    localparam bus_out_t BUS_IDLE = '{
        m1_l:     1'b1,
        mreq_l:   1'b1,
        iorq_l:   1'b1,
        rd_l:     1'b1,
        wr_l:     1'b1,
        rfsh_l:   1'b1,
        latch:    1'b0,
        done:     1'b0,
        drive:    1'b0,
        addr_sel: 1'b0
    };

    function automatic logic is_io(input bus_cyc_t ty);
        return (ty == IO_RD) || (ty == IO_WR);
    endfunction

    // Pure decode of (state, type); the caller registers the result so the
    // pins never see a combinational path from any input.
    function automatic bus_out_t decode_bus(input t_state_t st, input bus_cyc_t ty);
        bus_out_t o;
        o = BUS_IDLE;
        case (ty)
            FETCH: begin
                if (st == T1 || st == T2 || st == TW) begin
                    o.m1_l   = 1'b0;
                    o.mreq_l = 1'b0;
                    o.rd_l   = 1'b0;
                end else if (st == T3 || st == T4) begin
                    o.mreq_l   = 1'b0;
                    o.rfsh_l   = 1'b0;
                    o.addr_sel = 1'b1;
                    o.latch    = (st == T3);
                    o.done     = (st == T4);
                end
            end
            MEM_RD: begin
                if (st != IDLE && st != T4) begin
                    o.mreq_l = 1'b0;
                    o.rd_l   = 1'b0;
                    o.latch  = (st == T3);
                    o.done   = (st == T3);
                end
            end
            MEM_WR: begin
                if (st != IDLE && st != T4) begin
                    o.mreq_l = 1'b0;
                    o.drive  = 1'b1;
                    o.wr_l   = (st == T1);
                    o.done   = (st == T3);
                end
            end
            IO_RD, IO_WR: begin
                if (st != IDLE && st != T4) begin
                    o.drive = (ty == IO_WR);
                    // I/O strobes start one T-state late: T1 carries address only.
                    if (st != T1) begin
                        o.iorq_l = 1'b0;
                        if (ty == IO_RD) o.rd_l = 1'b0;
                        else             o.wr_l = 1'b0;
                    end
                    o.latch = (st == T3) && (ty == IO_RD);
                    o.done  = (st == T3);
                end
            end
            default: o = BUS_IDLE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/z80_refresh_ctr.sv
// z80_refresh_ctr: DRAM refresh (R) counter.
//   clk   - system clock
//   rst_L - asynchronous active-low reset, clears the count
//   inc   - advance the count by one on this edge (wraps mod 2^WIDTH)
//   count - current refresh counter value
module z80_refresh_ctr #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/z80_bus_cycle_fsm.sv
// z80_bus_cycle_fsm: M-cycle sequencer between Z80 control logic and bus pins.
//   clk, rst_L        - clock, asynchronous active-low reset
//   cyc_req, cyc_type - bus cycle request, sampled only while ready=1
//   WAIT_L            - external wait request (active low), honoured in T2/TW
//   ready             - a request is accepted on this edge
//   cyc_done          - pulse in the final T-state of a cycle
//   latch_data        - datapath loads data_bus into MDR on this edge
//   drive_data_en     - datapath drives data_out (write cycles)
//   addr_sel          - 1 selects the refresh address {I, rfsh_addr}
//   rfsh_addr         - refresh counter {1'b0, R[6:0]}
//   M1_L..RFSH_L      - active-low bus strobes
module z80_bus_cycle_fsm
    import z80_pkg::*;
#(
    parameter int unsigned IO_AUTO_WAIT = 1,
    parameter int unsigned RFSH_BITS    = 7
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       cyc_req,
    input  logic [2:0] cyc_type,
    input  logic       WAIT_L,
    output logic       ready,
    output logic       cyc_done,
    output logic       latch_data,
    output logic       drive_data_en,
    output logic       addr_sel,
    output logic [7:0] rfsh_addr,
    output logic       M1_L,
    output logic       MREQ_L,
    output logic       IORQ_L,
    output logic       RD_L,
    output logic       WR_L,
    output logic       RFSH_L
);

    // Index of the forced I/O wait state in which WAIT_L is finally sampled.
    localparam logic [1:0] AUTO_LAST = (IO_AUTO_WAIT == 0) ? 2'd0 : 2'(IO_AUTO_WAIT - 1);

    t_state_t             state, nxt_state;
    bus_cyc_t             cyc, nxt_cyc;
    logic     [1:0]       wait_cnt, nxt_cnt;
    bus_out_t             outs, nxt_outs;
    logic                 accept;
    logic [RFSH_BITS-1:0] r_cnt;

    always_comb begin
        nxt_state = state;
        nxt_cyc   = cyc;
        nxt_cnt   = wait_cnt;
        accept    = cyc_req && (cyc_type <= 3'd4);

        // A completing cycle is ready like IDLE, so a new request chains
        // straight into T1 with no idle gap.
        if (ready) begin
            if (accept) begin
                nxt_state = T1;
                nxt_cyc   = bus_cyc_t'(cyc_type);
            end else begin
                nxt_state = IDLE;
            end
        end else begin
            case (state)
                T1: begin
                    nxt_state = T2;
                    nxt_cnt   = '0;
                end
                T2: begin
                    if (is_io(cyc) && (IO_AUTO_WAIT != 0)) nxt_state = TW;
                    else                                    nxt_state = WAIT_L ? T3 : TW;
                end
                TW: begin
                    if (is_io(cyc) && (wait_cnt != AUTO_LAST)) begin
                        nxt_cnt = wait_cnt + 2'd1;
                    end else begin
                        nxt_state = WAIT_L ? T3 : TW;
                    end
                end
                T3:      nxt_state = (cyc == FETCH) ? T4 : IDLE;
                default: nxt_state = IDLE;
            endcase
        end

        nxt_outs = decode_bus(nxt_state, nxt_cyc);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state    <= IDLE;
            cyc      <= FETCH;
            wait_cnt <= '0;
            outs     <= BUS_IDLE;
            ready    <= 1'b1;
        end else begin
            state    <= nxt_state;
            cyc      <= nxt_cyc;
            wait_cnt <= nxt_cnt;
            outs     <= nxt_outs;
            ready    <= (nxt_state == IDLE) || nxt_outs.done;
        end
    end

    // R advances on the edge that ends the fetch T4.
    z80_refresh_ctr #(
        .WIDTH(RFSH_BITS)
    ) u_rfsh (
        .clk   (clk),
        .rst_L (rst_L),
        .inc   (state == T4),
        .count (r_cnt)
    );

    assign rfsh_addr     = 8'(r_cnt) & RFSH_MASK;
    assign M1_L          = outs.m1_l;
    assign MREQ_L        = outs.mreq_l;
    assign IORQ_L        = outs.iorq_l;
    assign RD_L          = outs.rd_l;
    assign WR_L          = outs.wr_l;
    assign RFSH_L        = outs.rfsh_l;
    assign latch_data    = outs.latch;
    assign cyc_done      = outs.done;
    assign drive_data_en = outs.drive;
    assign addr_sel      = outs.addr_sel;

endmodule

// File: tb/tb_z80_bus_cycle_fsm.sv
// tb_z80_bus_cycle_fsm: directed bench for z80_bus_cycle_fsm. A timeline
// model derives, from the stimulus schedule, which T-state each cycle is in,
// and per-strobe rules give the expected pins for that T-state.
module tb_z80_bus_cycle_fsm;

    localparam int N    = 600;
    localparam int AUTO = 1;
    localparam int P_IDLE = 0, P_T1 = 1, P_T2 = 2, P_TW = 3, P_T3 = 4, P_T4 = 5;

    logic       clk = 1'b0;
    logic       rst_L = 1'b1;
    logic       cyc_req = 1'b0;
    logic [2:0] cyc_type = 3'd0;
    logic       WAIT_L = 1'b1;
    logic       ready, cyc_done, latch_data, drive_data_en, addr_sel;
    logic [7:0] rfsh_addr;
    logic       M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;

    z80_bus_cycle_fsm #(
        .IO_AUTO_WAIT(AUTO),
        .RFSH_BITS(7)
    ) dut (
        .clk(clk), .rst_L(rst_L), .cyc_req(cyc_req), .cyc_type(cyc_type),
        .WAIT_L(WAIT_L), .ready(ready), .cyc_done(cyc_done),
        .latch_data(latch_data), .drive_data_en(drive_data_en),
        .addr_sel(addr_sel), .rfsh_addr(rfsh_addr), .M1_L(M1_L),
        .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .RFSH_L(RFSH_L)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cur = 0;
    bit model_on = 1'b0;

    bit req_s [N];
    int typ_s [N];
    bit wt_s  [N];
    int ph    [N];
    int ty    [N];
    bit last  [N];
    int rexp  [N];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d t=%0t got=%h want=%h", name, cur, $time, act, exp);
        end
    endtask

    // Lays out each accepted transaction as T1, T2, waits, T3 (, T4).
    // Waits = forced I/O waits + run of WAIT_L=0 starting at the first
    // sampled cycle (T2 for memory, last forced wait for I/O).
    task automatic build_model();
        int s, forced, extra, w, len, fetches;
        bit rdy;
        for (int n = 0; n < N; n++) begin
            ph[n] = P_IDLE; ty[n] = 0; last[n] = 1'b0;
        end
        for (int n = 0; n < N; n++) begin
            rdy = (ph[n] == P_IDLE) || last[n];
            if (rdy && req_s[n] && typ_s[n] <= 4) begin
                s      = n + 1;
                forced = (typ_s[n] == 3 || typ_s[n] == 4) ? AUTO : 0;
                extra  = 0;
                while (s + 1 + forced + extra < N && !wt_s[s + 1 + forced + extra]) extra++;
                w   = forced + extra;
                len = 3 + w + ((typ_s[n] == 0) ? 1 : 0);
                for (int k = 0; k < len && s + k < N; k++) begin
                    ty[s+k] = typ_s[n];
                    if (k == 0)          ph[s+k] = P_T1;
                    else if (k == 1)     ph[s+k] = P_T2;
                    else if (k < 2 + w)  ph[s+k] = P_TW;
                    else if (k == 2 + w) ph[s+k] = P_T3;
                    else                 ph[s+k] = P_T4;
                    last[s+k] = (k == len - 1);
                end
            end
        end
        fetches = 0;
        for (int n = 0; n < N; n++) begin
            rexp[n] = fetches % 128;
            if (ph[n] == P_T4) fetches++;
        end
    endtask

    always @(negedge clk) begin
        int  p, t;
        bit  a;
        if (model_on) begin
            p = ph[cur];
            t = ty[cur];
            a = (p != P_IDLE);
            chk("m1",    M1_L,   !(t == 0 && (p == P_T1 || p == P_T2 || p == P_TW)));
            chk("mreq",  MREQ_L, !(a && t <= 2));
            chk("iorq",  IORQ_L, !(a && t >= 3 && p != P_T1));
            chk("rd",    RD_L,   !((t == 0 && (p == P_T1 || p == P_T2 || p == P_TW)) ||
                                   (t == 1 && a) || (t == 3 && a && p != P_T1)));
            chk("wr",    WR_L,   !((t == 2 || t == 4) && a && p != P_T1));
            chk("rfsh",  RFSH_L, !(t == 0 && p >= P_T3));
            chk("asel",  addr_sel, (t == 0 && p >= P_T3));
            chk("latch", latch_data, (p == P_T3 && (t == 0 || t == 1 || t == 3)));
            chk("done",  cyc_done, last[cur]);
            chk("drive", drive_data_en, (a && (t == 2 || t == 4)));
            chk("ready", ready, (p == P_IDLE) || last[cur]);
            chk("raddr", rfsh_addr, 8'(rexp[cur]));

            case (cur)
                3:   begin chk("lit_f_m1", M1_L, 0); chk("lit_f_rd", RD_L, 0); chk("lit_f_rfsh1", RFSH_L, 1); end
                5:   begin chk("lit_f_m1hi", M1_L, 1); chk("lit_f_rfsh3", RFSH_L, 0); chk("lit_f_latch", latch_data, 1); end
                6:   begin chk("lit_f_done", cyc_done, 1); chk("lit_f_r0", rfsh_addr, 8'h00); end
                7:   chk("lit_f_r1", rfsh_addr, 8'h01);
                14:  begin chk("lit_mr_tw_rd", RD_L, 0); chk("lit_mr_tw_latch", latch_data, 0); end
                15:  begin chk("lit_mr_latch", latch_data, 1); chk("lit_mr_done", cyc_done, 1); end
                21:  chk("lit_mw_t1_wr", WR_L, 1);
                22:  chk("lit_mw_t2_wr", WR_L, 0);
                23:  chk("lit_mw_ready", ready, 1);
                24:  begin chk("lit_io_t1_iorq", IORQ_L, 1); chk("lit_io_t1_wr", WR_L, 1); end
                25:  begin chk("lit_io_t2_iorq", IORQ_L, 0); chk("lit_io_t2_rd", RD_L, 0); end
                27:  begin chk("lit_io_done", cyc_done, 1); chk("lit_io_latch", latch_data, 1); end
                35:  chk("lit_iow_done", cyc_done, 1);
                43:  begin chk("lit_rsv_ready", ready, 1); chk("lit_rsv_mreq", MREQ_L, 1); end
                555: chk("lit_r_7f", rfsh_addr, 8'h7F);
                559: chk("lit_r_wrap", rfsh_addr, 8'h00);
                599: chk("lit_r_end", rfsh_addr, 8'h03);
                default: ;
            endcase
        end
    end

    initial begin
        for (int n = 0; n < N; n++) begin
            req_s[n] = 1'b0; typ_s[n] = 0; wt_s[n] = 1'b1;
        end
        // single fetch
        req_s[2] = 1'b1; typ_s[2] = 0;
        // memory read with two wait states
        req_s[10] = 1'b1; typ_s[10] = 1; wt_s[12] = 1'b0; wt_s[13] = 1'b0;
        // back-to-back memory write then I/O read, request held high
        for (int n = 20; n <= 26; n++) begin
            req_s[n] = 1'b1; typ_s[n] = (n <= 22) ? 2 : 3;
        end
        // I/O write: WAIT_L low in T1/T2 ignored, low in last forced wait honoured
        req_s[30] = 1'b1; typ_s[30] = 4;
        wt_s[31] = 1'b0; wt_s[32] = 1'b0; wt_s[33] = 1'b0;
        // reserved type
        for (int n = 40; n <= 42; n++) begin
            req_s[n] = 1'b1; typ_s[n] = 6;
        end
        // 130 chained fetches, enough to wrap R
        for (int n = 50; n <= 569; n++) begin
            req_s[n] = 1'b1; typ_s[n] = 0;
        end
        build_model();

        #1 rst_L = 1'b0;
        #11;
        chk("rst_ready", ready, 1);
        chk("rst_m1", M1_L, 1);
        chk("rst_mreq", MREQ_L, 1);
        chk("rst_iorq", IORQ_L, 1);
        chk("rst_rd", RD_L, 1);
        chk("rst_wr", WR_L, 1);
        chk("rst_rfsh", RFSH_L, 1);
        chk("rst_done", cyc_done, 0);
        chk("rst_latch", latch_data, 0);
        chk("rst_drive", drive_data_en, 0);
        chk("rst_asel", addr_sel, 0);
        chk("rst_raddr", rfsh_addr, 8'h00);
        #10 rst_L = 1'b1;

        for (int n = 0; n < N; n++) begin
            @(posedge clk);
            #1;
            cur      = n;
            model_on = 1'b1;
            cyc_req  = req_s[n];
            cyc_type = 3'(typ_s[n]);
            WAIT_L   = wt_s[n];
        end
        @(posedge clk);
        #1;
        model_on = 1'b0;
        cyc_req  = 1'b0;
        WAIT_L   = 1'b1;

        // reset while a fetch is stretched in TW
        cyc_req = 1'b1; cyc_type = 3'd0; WAIT_L = 1'b0;
        @(posedge clk); #1 cyc_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("tw_m1", M1_L, 0);
        chk("tw_rd", RD_L, 0);
        chk("tw_ready", ready, 0);
        chk("tw_raddr", rfsh_addr, 8'h03);
        #2 rst_L = 1'b0;
        #1;
        chk("arst_m1", M1_L, 1);
        chk("arst_mreq", MREQ_L, 1);
        chk("arst_rd", RD_L, 1);
        chk("arst_ready", ready, 1);
        chk("arst_done", cyc_done, 0);
        chk("arst_raddr", rfsh_addr, 8'h00);
        @(negedge clk);
        rst_L  = 1'b1;
        WAIT_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_done", cyc_done, 0);
            chk("post_ready", ready, 1);
            chk("post_mreq", MREQ_L, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
